pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit; successor to the 8/16-bit PCcnt block. Adds configurable widths, an explicit opcode-driven next-PC select, absolute/relative/indirect jumps and a hardware return-address stack (RAS) for call/return. It sits between the control FSM and the instruction memory address port and drives the fetch address every cycle.

## Interface
- PC_W, 16, PC and base width (≥8)
- OFF_W, 8, signed offset width (2..PC_W)
- STEP, 1, increment per sequential fetch
- RAS_DEPTH, 4, return-stack entries (power of two, 2..16)
- RESET_PC, 0, PC value after reset
- TRAP_VEC, 16'hFFF0 (resized to PC_W), trap target (used only with PC_UNIT_TRAP_EN)

- clk  in  1  single clock, rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- pc_en  in  1  advance enable; low = hold PC and RAS
- pc_op  in  3  next-PC operation (see Operation)
- pc_offset  in  OFF_W  signed offset, sign-extended to PC_W
- pc_base  in  PC_W  base/absolute address
- pc  out  PC_W  current program counter (registered)
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries
- ras_full  out  1  ras_count == RAS_DEPTH
- ras_empty  out  1  ras_count == 0
- ras_err  out  1  sticky overflow/underflow flag, cleared only by rst
- trap  out  1  one-cycle pulse on RAS fault (0 when macro absent)

## Operation
- ext = sign-extend(pc_offset) to PC_W; all sums modulo 2^PC_W, silent wrap.
- pc_op, applied on rising edge when pc_en=1:
  - 000 HOLD: pc unchanged
  - 001 INC: pc ← pc + STEP
  - 010 BR_REL: pc ← pc + ext
  - 011 JMP_ABS: pc ← pc_base + ext
  - 100 JMP_IND: pc ← pc + pc_base + ext
  - 101 CALL: push pc + STEP; pc ← pc_base + ext
  - 110 RET: pc ← top; pop
  - 111 reserved: treated as HOLD
- pc_en=0: pc, RAS, ras_err unchanged; trap=0.
- RAS: LIFO, write pointer plus count; push/pop only via CALL/RET.
- CALL when full (without trap): oldest entry overwritten (circular), count stays RAS_DEPTH, ras_err←1, jump still taken.
- RET when empty (without trap): pc ← pc + STEP, count stays 0, ras_err←1.
- Reset values: pc=RESET_PC, ras_count=0, ras_empty=1, ras_full=0, ras_err=0, trap=0; RAS contents don't-care.
- rst has priority over pc_en/pc_op; reset mid-call discards the push.

## Timing
- pc updates one cycle after the op is sampled; zero extra latency.
- Status flags (ras_count/full/empty) registered, consistent with pc in same cycle.
- RET in the cycle after CALL returns the just-pushed address (no bypass hazard; stack is registered, top read combinationally).
- trap asserted in the same cycle pc shows TRAP_VEC, for exactly one cycle.
- Back-to-back ops every cycle supported; no stall output.

## Configuration
- PC_UNIT_TRAP_EN defined: CALL on full and RET on empty do not touch the RAS; pc ← TRAP_VEC, trap pulses 1 cycle, ras_err←1.
- Undefined: overflow/underflow behaviour as in Operation; trap tied 0; TRAP_VEC unused.

## Structure
- pc_unit_pkg: pc_op encoding constants (OP_HOLD..OP_RSVD), op width 3.
- Sub-module pc_ras: parametrised LIFO (DEPTH, W) with push, pop, top, count, full, empty; pc_unit holds next-PC mux, sign extension, fault logic.

## Test plan
- rst=1 for 2 cycles, RESET_PC=16'h0100 → pc=0x0100, ras_empty=1, ras_err=0; then INC×3 with pc_en=1 → 0x0103.
- pc=0x0010, BR_REL offset 8'hF0 → pc=0x0000; then BR_REL 8'h80 from 0x0000 → 0xFF80 (wrap).
- pc=0x0020, CALL base=0x0400 off=2 → pc=0x0402, ras_count=1; RET next cycle → pc=0x0021, ras_empty=1.
- 5 nested CALLs with RAS_DEPTH=4, no macro → ras_err=1, count=4; 4 RETs return to calls 5,4,3,2 addresses; 5th RET → pc+1, ras_err stays 1.
- With PC_UNIT_TRAP_EN: RET on empty → pc=TRAP_VEC, trap high exactly 1 cycle, ras_count=0.
- pc_en=0 with pc_op=CALL for 3 cycles → pc and ras_count unchanged; assert rst during a CALL cycle → pc=RESET_PC, ras_count=0.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter unit: next-PC operation encoding.
package pc_unit_pkg;

  localparam int unsigned OP_W = 3;

  typedef logic [OP_W-1:0] pc_op_t;

  localparam pc_op_t OP_HOLD    = 3'b000;
  localparam pc_op_t OP_INC     = 3'b001;
  localparam pc_op_t OP_BR_REL  = 3'b010;
  localparam pc_op_t OP_JMP_ABS = 3'b011;
  localparam pc_op_t OP_JMP_IND = 3'b100;
  localparam pc_op_t OP_CALL    = 3'b101;
  localparam pc_op_t OP_RET     = 3'b110;
  localparam pc_op_t OP_RSVD    = 3'b111;

endpackage

// File: rtl/pc_unit_ras.sv
// Return-address stack: circular LIFO with write pointer and saturating count.
// A push when full overwrites the oldest entry; top is read combinationally.
module pc_ras #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wp_q, wp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    wp_d  = wp_q;
    cnt_d = cnt_q;
    if (push) begin
      wp_d = wp_q + PW'(1);
      if (!full) cnt_d = cnt_q + CW'(1);
    end else if (pop && !empty) begin
      wp_d  = wp_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
    end
  end

  // Contents need no reset; a push coinciding with rst is dropped.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wp_q] <= din;
  end

  assign top   = mem_q[wp_q - PW'(1)];
  assign count = cnt_q;
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: opcode-selected next PC with call/return stack.
// Define PC_UNIT_TRAP_EN to redirect RAS overflow/underflow to TRAP_VEC with a trap pulse.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int unsigned     PC_W      = 16,
  parameter int unsigned     OFF_W     = 8,
  parameter int unsigned     STEP      = 1,
  parameter int unsigned     RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0
`ifdef PC_UNIT_TRAP_EN
  ,
  parameter logic [PC_W-1:0] TRAP_VEC  = PC_W'(16'hFFF0)
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pc_en,
  input  logic [OP_W-1:0]             pc_op,
  input  logic [OFF_W-1:0]            pc_offset,
  input  logic [PC_W-1:0]             pc_base,
  output logic [PC_W-1:0]             pc,
  output logic [$clog2(RAS_DEPTH):0]  ras_count,
  output logic                        ras_full,
  output logic                        ras_empty,
  output logic                        ras_err,
  output logic                        trap
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            err_q, err_d;
  logic [PC_W-1:0] ext, seq_pc, abs_pc, ras_top;
  logic            push, pop;

  assign ext    = PC_W'($signed(pc_offset));
  assign seq_pc = pc_q + PC_W'(STEP);
  assign abs_pc = pc_base + ext;

`ifdef PC_UNIT_TRAP_EN
  logic trap_q, trap_d;
`endif

  always_comb begin
    pc_d  = pc_q;
    err_d = err_q;
    push  = 1'b0;
    pop   = 1'b0;
`ifdef PC_UNIT_TRAP_EN
    trap_d = 1'b0;
`endif
    if (pc_en) begin
      case (pc_op)
        OP_INC:     pc_d = seq_pc;
        OP_BR_REL:  pc_d = pc_q + ext;
        OP_JMP_ABS: pc_d = abs_pc;
        OP_JMP_IND: pc_d = pc_q + pc_base + ext;
        OP_CALL: begin
          if (ras_full) begin
            err_d = 1'b1;
`ifdef PC_UNIT_TRAP_EN
            pc_d   = TRAP_VEC;
            trap_d = 1'b1;
`else
            push = 1'b1;
            pc_d = abs_pc;
`endif
          end else begin
            push = 1'b1;
            pc_d = abs_pc;
          end
        end
        OP_RET: begin
          if (ras_empty) begin
            err_d = 1'b1;
`ifdef PC_UNIT_TRAP_EN
            pc_d   = TRAP_VEC;
            trap_d = 1'b1;
`else
            pc_d = seq_pc;
`endif
          end else begin
            pop  = 1'b1;
            pc_d = ras_top;
          end
        end
        default: pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

`ifdef PC_UNIT_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) trap_q <= 1'b0;
    else     trap_q <= trap_d;
  end
  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (seq_pc),
    .top   (ras_top),
    .count (ras_count),
    .full  (ras_full),
    .empty (ras_empty)
  );

  assign pc      = pc_q;
  assign ras_err = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: stimulus queues expected state, a negedge monitor compares.
module tb_pc_unit;
  import pc_unit_pkg::*;

`ifdef PC_UNIT_TRAP_EN
  localparam bit TE = 1'b1;
`else
  localparam bit TE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, pc_en;
  logic [2:0]  pc_op;
  logic [7:0]  pc_offset;
  logic [15:0] pc_base;
  logic [15:0] pc;
  logic [2:0]  ras_count;
  logic        ras_full, ras_empty, ras_err, trap;

  pc_unit #(
    .PC_W      (16),
    .OFF_W     (8),
    .STEP      (1),
    .RAS_DEPTH (4),
    .RESET_PC  (16'h0100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_en     (pc_en),
    .pc_op     (pc_op),
    .pc_offset (pc_offset),
    .pc_base   (pc_base),
    .pc        (pc),
    .ras_count (ras_count),
    .ras_full  (ras_full),
    .ras_empty (ras_empty),
    .ras_err   (ras_err),
    .trap      (trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] pc;
    logic [2:0]  cnt;
    logic        full, empty, err, trap;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic step(input string name, input logic r, input logic en, input logic [2:0] op,
                      input logic [7:0] off, input logic [15:0] base, input logic [15:0] epc,
                      input int ecnt, input logic eerr, input logic etrap);
    exp_t e;
    rst = r; pc_en = en; pc_op = op; pc_offset = off; pc_base = base;
    e.name = name; e.pc = epc; e.cnt = 3'(ecnt);
    e.full = (ecnt == 4); e.empty = (ecnt == 0); e.err = eerr; e.trap = etrap;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  exp_t m;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      m = sb.pop_front();
      checks++;
      if ({pc, ras_count, ras_full, ras_empty, ras_err, trap} !==
          {m.pc, m.cnt, m.full, m.empty, m.err, m.trap}) begin
        errors++;
        $display("FAIL %s: got pc=%h cnt=%0d full=%b empty=%b err=%b trap=%b, want pc=%h cnt=%0d full=%b empty=%b err=%b trap=%b",
                 m.name, pc, ras_count, ras_full, ras_empty, ras_err, trap,
                 m.pc, m.cnt, m.full, m.empty, m.err, m.trap);
      end
    end
  end

  initial begin
    step("reset0",   1, 1, OP_INC,     8'h00, 16'h0000, 16'h0100, 0, 0, 0);
    step("reset1",   1, 1, OP_INC,     8'h00, 16'h0000, 16'h0100, 0, 0, 0);
    step("inc1",     0, 1, OP_INC,     8'h00, 16'h0000, 16'h0101, 0, 0, 0);
    step("inc2",     0, 1, OP_INC,     8'h00, 16'h0000, 16'h0102, 0, 0, 0);
    step("inc3",     0, 1, OP_INC,     8'h00, 16'h0000, 16'h0103, 0, 0, 0);
    step("jabs",     0, 1, OP_JMP_ABS, 8'h00, 16'h0010, 16'h0010, 0, 0, 0);
    step("brneg",    0, 1, OP_BR_REL,  8'hF0, 16'h0000, 16'h0000, 0, 0, 0);
    step("brwrap",   0, 1, OP_BR_REL,  8'h80, 16'h0000, 16'hFF80, 0, 0, 0);
    step("jind",     0, 1, OP_JMP_IND, 8'h01, 16'h0100, 16'h0081, 0, 0, 0);
    step("jabs2",    0, 1, OP_JMP_ABS, 8'h00, 16'h0020, 16'h0020, 0, 0, 0);
    step("call",     0, 1, OP_CALL,    8'h02, 16'h0400, 16'h0402, 1, 0, 0);
    step("ret",      0, 1, OP_RET,     8'h00, 16'h0000, 16'h0021, 0, 0, 0);
    step("hold",     0, 1, OP_HOLD,    8'h55, 16'h1234, 16'h0021, 0, 0, 0);
    step("rsvd",     0, 1, OP_RSVD,    8'h55, 16'h1234, 16'h0021, 0, 0, 0);
    step("ncall1",   0, 1, OP_CALL,    8'h00, 16'h1000, 16'h1000, 1, 0, 0);
    step("ncall2",   0, 1, OP_CALL,    8'h00, 16'h2000, 16'h2000, 2, 0, 0);
    step("ncall3",   0, 1, OP_CALL,    8'h00, 16'h3000, 16'h3000, 3, 0, 0);
    step("ncall4",   0, 1, OP_CALL,    8'h00, 16'h4000, 16'h4000, 4, 0, 0);
    step("ncall5",   0, 1, OP_CALL,    8'h00, 16'h5000, TE ? 16'hFFF0 : 16'h5000, 4, 1, TE);
    step("nret1",    0, 1, OP_RET,     8'h00, 16'h0000, TE ? 16'h3001 : 16'h4001, 3, 1, 0);
    step("nret2",    0, 1, OP_RET,     8'h00, 16'h0000, TE ? 16'h2001 : 16'h3001, 2, 1, 0);
    step("nret3",    0, 1, OP_RET,     8'h00, 16'h0000, TE ? 16'h1001 : 16'h2001, 1, 1, 0);
    step("nret4",    0, 1, OP_RET,     8'h00, 16'h0000, TE ? 16'h0022 : 16'h1001, 0, 1, 0);
    step("nret5",    0, 1, OP_RET,     8'h00, 16'h0000, TE ? 16'hFFF0 : 16'h1002, 0, 1, TE);
    step("call6",    0, 1, OP_CALL,    8'hFE, 16'h0600, 16'h05FE, 1, 1, 0);
    step("en0a",     0, 0, OP_CALL,    8'h00, 16'h0700, 16'h05FE, 1, 1, 0);
    step("en0b",     0, 0, OP_CALL,    8'h00, 16'h0700, 16'h05FE, 1, 1, 0);
    step("en0c",     0, 0, OP_CALL,    8'h00, 16'h0700, 16'h05FE, 1, 1, 0);
    step("ret6",     0, 1, OP_RET,     8'h00, 16'h0000, TE ? 16'hFFF1 : 16'h1003, 0, 1, 0);
    step("call7",    0, 1, OP_CALL,    8'hFE, 16'h0600, 16'h05FE, 1, 1, 0);
    step("rstcall",  1, 1, OP_CALL,    8'h00, 16'h0800, 16'h0100, 0, 0, 0);
    step("retempty", 0, 1, OP_RET,     8'h00, 16'h0000, TE ? 16'hFFF0 : 16'h0101, 0, 1, TE);
    step("incafter", 0, 1, OP_INC,     8'h00, 16'h0000, TE ? 16'hFFF1 : 16'h0102, 0, 1, 0);
    pc_en = 1'b0;
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
